// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous FIFO with registered or first-word-fall-through read,
// margin flags, sticky error flags and optional end-of-frame tracking.
module sync_fifo_fwft #(
    parameter int WIDTH        = 8,
    parameter int SIZE         = 5,
    parameter int FULL_MARGIN  = 0,
    parameter int EMPTY_MARGIN = 0,
    parameter int FWFT         = 0,
    parameter int EOF          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             eof_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [SIZE:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_empty,
    output logic             eof,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam int DEPTH = 1 << SIZE;
    localparam logic [SIZE:0] DEPTH_C = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0] FULL_TH = FULL_MARGIN >= DEPTH ? '0 : (SIZE+1)'(DEPTH - FULL_MARGIN);
    localparam logic [SIZE:0] AE_TH = EMPTY_MARGIN >= DEPTH ? DEPTH_C : (SIZE+1)'(EMPTY_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  w_ptr, r_ptr;
    logic [SIZE:0]    count_next, stored;
    logic             empty_q, eof_flag, w_ok, rd, slot, load_mem, load_in, adv;

    // In FWFT mode the output register is refilled whenever it is free or being popped;
    // a write into a FIFO with nothing stored behind the head goes straight to data_out.
    always_comb begin
        w_ok       = w_en && !eof && count != DEPTH_C;
        rd         = FWFT != 0 ? r_en && valid : r_en && !empty_q;
        stored     = count - {{SIZE{1'b0}}, valid};
        slot       = FWFT != 0 && (!valid || rd);
        load_mem   = slot && stored != '0;
        load_in    = slot && stored == '0 && w_ok;
        adv        = FWFT != 0 ? load_mem || load_in : rd;
        count_next = count + {{SIZE{1'b0}}, w_ok} - {{SIZE{1'b0}}, rd};
    end

    assign empty = FWFT != 0 ? !valid : empty_q;

    always_ff @(posedge clk)
        if (w_ok) mem[w_ptr] <= data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr         <= '0;
            r_ptr         <= '0;
            count         <= '0;
            full          <= FULL_MARGIN >= DEPTH;
            empty_q       <= 1'b1;
            almost_empty  <= 1'b1;
            valid         <= 1'b0;
            data_out      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            eof_flag      <= 1'b0;
            eof           <= 1'b0;
        end else begin
            w_ptr         <= w_ptr + SIZE'(w_ok);
            r_ptr         <= r_ptr + SIZE'(adv);
            count         <= count_next;
            full          <= count_next >= FULL_TH;
            empty_q       <= count_next == '0;
            almost_empty  <= count_next <= AE_TH;
            valid         <= FWFT != 0 ? (valid && !rd) || load_mem || load_in : rd;
            data_out      <= load_in ? data_in : (load_mem || (FWFT == 0 && rd)) ? mem[r_ptr] : data_out;
            err_overflow  <= err_overflow || (w_en && !w_ok);
            err_underflow <= err_underflow || (r_en && !rd);
            eof_flag      <= eof_flag || (EOF != 0 && eof_in);
            eof           <= eof || (eof_flag && count == '0 && !w_en);
        end
    end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: randomized scoreboard bench for a standard-mode and an FWFT/EOF instance
// against queue-based reference models.
module tb_sync_fifo_fwft;
    logic clk = 1'b0, rst = 1'b1;
    logic s_w = 0, s_r = 0, s_eof_in = 0, f_w = 0, f_r = 0, f_eof_in = 0;
    logic [7:0] s_d = 0, f_d = 0, s_data, f_data;
    logic [2:0] s_count, f_count;
    logic s_valid, s_full, s_empty, s_ae, s_eof, s_ov, s_uf;
    logic f_valid, f_full, f_empty, f_ae, f_eof, f_ov, f_uf;

    int passed = 0, total = 0;
    logic [7:0] qs[$], qf[$], exp_s[$], exp_f[$];
    bit ov_s, uf_s, ov_f, uf_f, fl_f, eof_m;

    sync_fifo_fwft #(.WIDTH(8), .SIZE(2), .FULL_MARGIN(1), .EMPTY_MARGIN(0), .FWFT(0), .EOF(0)) u_std (
        .clk(clk), .rst(rst), .w_en(s_w), .data_in(s_d), .eof_in(s_eof_in), .r_en(s_r),
        .data_out(s_data), .valid(s_valid), .count(s_count), .full(s_full), .empty(s_empty),
        .almost_empty(s_ae), .eof(s_eof), .err_overflow(s_ov), .err_underflow(s_uf));

    sync_fifo_fwft #(.WIDTH(8), .SIZE(2), .FULL_MARGIN(0), .EMPTY_MARGIN(1), .FWFT(1), .EOF(1)) u_fw (
        .clk(clk), .rst(rst), .w_en(f_w), .data_in(f_d), .eof_in(f_eof_in), .r_en(f_r),
        .data_out(f_data), .valid(f_valid), .count(f_count), .full(f_full), .empty(f_empty),
        .almost_empty(f_ae), .eof(f_eof), .err_overflow(f_ov), .err_underflow(f_uf));

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp_v, $time);
    endtask

    // Standard mode: every valid pulse must deliver the next expected read word.
    always @(negedge clk)
        if (s_valid) begin
            if (exp_s.size() == 0) begin
                total++;
                $display("FAIL s_data: unexpected valid pulse with data %0d at %0t", s_data, $time);
            end else chk("s_data", s_data, exp_s.pop_front());
        end

    // FWFT mode: a pop is valid && r_en; the word presented must be the expected one.
    always @(negedge clk)
        if (f_valid && f_r) begin
            if (exp_f.size() == 0) begin
                total++;
                $display("FAIL f_data: unexpected pop of %0d at %0t", f_data, $time);
            end else chk("f_data", f_data, exp_f.pop_front());
        end

    task automatic step(input bit ws, input logic [7:0] ds, input bit rs,
                        input bit wf, input logic [7:0] df, input bit rf, input bit ef);
        bit acc, rd, eof_nx;
        s_w = ws; s_d = ds; s_r = rs; f_w = wf; f_d = df; f_r = rf; f_eof_in = ef;
        rd  = rs && qs.size() > 0;
        acc = ws && qs.size() != 4;
        ov_s |= ws && !acc;
        uf_s |= rs && qs.size() == 0;
        if (rd) exp_s.push_back(qs.pop_front());
        if (acc) qs.push_back(ds);
        rd  = rf && qf.size() > 0;
        acc = wf && !eof_m && qf.size() != 4;
        ov_f |= wf && !acc;
        uf_f |= rf && qf.size() == 0;
        eof_nx = eof_m || (fl_f && qf.size() == 0 && !wf);
        fl_f |= ef;
        eof_m = eof_nx;
        if (rd) exp_f.push_back(qf.pop_front());
        if (acc) qf.push_back(df);
        @(posedge clk);
        #1;
        chk("s_count", s_count, qs.size());
        chk("s_full", s_full, qs.size() >= 3);
        chk("s_empty", s_empty, qs.size() == 0);
        chk("s_almost_empty", s_ae, qs.size() == 0);
        chk("s_err_overflow", s_ov, ov_s);
        chk("s_err_underflow", s_uf, uf_s);
        chk("s_eof", s_eof, 0);
        chk("f_count", f_count, qf.size());
        chk("f_valid", f_valid, qf.size() > 0);
        chk("f_empty", f_empty, qf.size() == 0);
        chk("f_almost_empty", f_ae, qf.size() <= 1);
        chk("f_full", f_full, qf.size() >= 4);
        chk("f_eof", f_eof, eof_m);
        chk("f_err_overflow", f_ov, ov_f);
        chk("f_err_underflow", f_uf, uf_f);
        if (qf.size() > 0) chk("f_head", f_data, qf[0]);
    endtask

    task automatic check_reset();
        chk("rst_s_count", s_count, 0);   chk("rst_s_valid", s_valid, 0);
        chk("rst_s_empty", s_empty, 1);   chk("rst_s_full", s_full, 0);
        chk("rst_s_ae", s_ae, 1);         chk("rst_s_data", s_data, 0);
        chk("rst_s_ov", s_ov, 0);         chk("rst_s_uf", s_uf, 0);
        chk("rst_f_count", f_count, 0);   chk("rst_f_valid", f_valid, 0);
        chk("rst_f_empty", f_empty, 1);   chk("rst_f_full", f_full, 0);
        chk("rst_f_ae", f_ae, 1);         chk("rst_f_data", f_data, 0);
        chk("rst_f_eof", f_eof, 0);       chk("rst_f_ov", f_ov, 0);
        chk("rst_f_uf", f_uf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 0;
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'hA5, 0, 0);
        chk("f_a5_head", f_data, 8'hA5);
        step(0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'($urandom_range(0, 255)), 0, 1, 8'(8'h10 + i), 0, 0);
        step(1, 8'hEE, 1, 1, 8'hEF, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 8'($urandom_range(0, 255)), 1, 0);
        for (int i = 0; i < 250; i++)
            step($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 5,
                 $urandom_range(0, 9) < 5, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 5, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 8'h31, 0, 0);
        step(0, 0, 0, 1, 8'h32, 0, 0);
        step(0, 0, 0, 1, 8'h33, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h44, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0, 1, 8'(8'h60 + i), 0, 0);
        {s_w, s_r, f_w, f_r, f_eof_in} = '0;
        #2 rst = 1;
        #1 check_reset();
        rst = 0;
        qs.delete(); qf.delete();
        {ov_s, uf_s, ov_f, uf_f, fl_f, eof_m} = '0;
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 0, 1, 0);
        step(1, 8'h3C, 0, 1, 8'hC3, 0, 0);
        step(1, 8'h3D, 1, 1, 8'hC4, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s_pending", exp_s.size(), 0);
        chk("f_pending", exp_f.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
